// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: access-size encodings, LSU FSM states and the store merge helper.
package load_store_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RMW_RD = 2'b01,
        ST_RMW_WR = 2'b10
    } lsu_state_t;

    // Replace the addressed byte or half lane of a memory word with store data.
    function automatic logic [31:0] merge_word(input logic [31:0] word, input logic [15:0] data,
                                               input logic [1:0] lane, input logic half);
        merge_word = word;
        if (half)
            merge_word[{lane[1], 4'b0000} +: 16] = data;
        else
            merge_word[{lane, 3'b000} +: 8] = data[7:0];
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_load_align: little-endian lane extract of a memory word with sign/zero extension.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    always_comb
        o_data = (i_size == SIZE_BYTE) ? {{24{w_byte[7] & ~i_unsigned}}, w_byte} :
                 (i_size == SIZE_HALF) ? {{16{w_half[15] & ~i_unsigned}}, w_half} : i_word;

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores onto a word memory; sub-word stores use a read-modify-write.
// Optional ALIGN_CHECK_EN: flag and suppress misaligned half/word accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DM_IDX_W = 17
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_mem_req,
    input  logic        i_mem_we,
    input  logic [1:0]  i_mem_size,
    input  logic        i_mem_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_stall,
    output logic [31:0] o_dm_addr,
    output logic        o_dm_we,
    output logic [31:0] o_dm_wdata,
    input  logic [31:0] i_dm_rdata,
    output logic        o_align_err
);

    lsu_state_t            r_state;
    lsu_state_t            w_next;
    logic [DM_IDX_W+1:0]   r_addr;
    logic [DM_IDX_W+1:0]   w_addr;
    logic [15:0]           r_wdata;
    logic                  r_half;
    logic [31:0]           r_merge;
    logic [31:0]           w_merged;
    logic [31:0]           w_load;
    logic                  w_idle;
    logic                  w_err;
    logic                  w_act;
    logic                  w_sub;
    logic                  w_unused;

    assign w_idle = r_state == ST_IDLE;

`ifdef ALIGN_CHECK_EN
    assign w_err = w_idle & i_mem_req & ~i_reset &
                   (i_mem_size[1] ? (i_addr[1:0] != 2'b00) : ((i_mem_size == SIZE_HALF) & i_addr[0]));
`else
    assign w_err = 1'b0;
`endif

    // Reset gates the Mealy outputs so nothing is requested while reset is held.
    assign o_align_err = w_err;
    assign w_act       = w_idle & i_mem_req & ~w_err & ~i_reset;
    assign w_sub       = w_act & i_mem_we & ~i_mem_size[1];
    assign w_addr      = w_idle ? i_addr[DM_IDX_W+1:0] : r_addr;
    assign o_dm_addr   = {{(32-DM_IDX_W){1'b0}}, w_addr[DM_IDX_W+1:2]};
    assign w_merged    = merge_word(i_dm_rdata, r_wdata, r_addr[1:0], r_half);
    assign w_unused    = ^i_addr[31:DM_IDX_W+2];

    lsu_load_align u_align (
        .i_word     (i_dm_rdata),
        .i_lane     (i_addr[1:0]),
        .i_size     (i_mem_size),
        .i_unsigned (i_mem_unsigned),
        .o_data     (w_load)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_half  <= 1'b0;
            r_merge <= '0;
        end else begin
            if (w_sub) begin
                r_addr  <= i_addr[DM_IDX_W+1:0];
                r_wdata <= i_wdata[15:0];
                r_half  <= i_mem_size == SIZE_HALF;
            end
            if (r_state == ST_RMW_RD)
                r_merge <= w_merged;
        end
    end

    always_comb begin
        w_next     = r_state;
        o_stall    = 1'b0;
        o_dm_we    = 1'b0;
        o_dm_wdata = '0;
        o_rdata    = '0;
        case (r_state)
            ST_IDLE: begin
                o_rdata    = (w_act & ~i_mem_we) ? w_load : '0;
                o_dm_we    = w_act & i_mem_we & i_mem_size[1];
                o_dm_wdata = (w_act & i_mem_we & i_mem_size[1]) ? i_wdata : '0;
                o_stall    = w_sub;
                w_next     = w_sub ? ST_RMW_RD : ST_IDLE;
            end
            ST_RMW_RD: begin
                o_stall = 1'b1;
                w_next  = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                o_dm_we    = 1'b1;
                o_dm_wdata = r_merge;
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed stimulus against a word memory model; a negedge monitor checks loads and writes from queues.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic [31:0] dm_addr;
    logic        dm_we;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        align_err;
    logic        pre;
    logic [31:0] mem [0:31];
    logic [31:0] load_q [$];
    logic [63:0] wr_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_mem_req      (req),
        .i_mem_we       (we),
        .i_mem_size     (size),
        .i_mem_unsigned (uns),
        .i_addr         (addr),
        .i_wdata        (wdata),
        .o_rdata        (rdata),
        .o_stall        (stall),
        .o_dm_addr      (dm_addr),
        .o_dm_we        (dm_we),
        .o_dm_wdata     (dm_wdata),
        .i_dm_rdata     (dm_rdata),
        .o_align_err    (align_err)
    );

    assign dm_rdata = mem[dm_addr[4:0]];

    always @(posedge clk) begin
        if (dm_we)
            mem[dm_addr[4:0]] <= dm_wdata;
        else if (pre)
            for (int i = 0; i < 32; i++)
                mem[i] <= (i == 4) ? 32'h8899AABB : 32'h0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst) begin
            if (dm_we) begin
                if (wr_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected write: got %h @ %h expected none", dm_wdata, dm_addr);
                end else begin
                    e = wr_q.pop_front();
                    chk("write addr", dm_addr, e[63:32]);
                    chk("write data", dm_wdata, e[31:0]);
                end
            end
            if (req && !we && !stall) begin
                if (load_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected load: got %h expected none", rdata);
                end else
                    chk("load rdata", rdata, load_q.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        req = r; we = w; size = s; uns = u; addr = a; wdata = d;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, SIZE_BYTE, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic preload;
        pre = 1'b1;
        tick();
        pre = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] s, input logic u, input logic [31:0] exp);
        drive(1'b1, 1'b0, s, u, a, 32'h0);
        load_q.push_back(exp);
        @(negedge clk);
        chk("load stall", stall, 0);
        chk("load dm_addr", dm_addr, a >> 2);
        tick();
        idle();
    endtask

    // The store inputs are replaced by a conflicting word store during RMW to prove they are ignored.
    task automatic store_sub(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d, input logic [31:0] exp);
        drive(1'b1, 1'b1, s, 1'b0, a, d);
        wr_q.push_back({a >> 2, exp});
        @(negedge clk);
        chk("rmw issue stall", stall, 1);
        chk("rmw issue dm_we", dm_we, 0);
        tick();
        drive(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h20, 32'hFFFFFFFF);
        @(negedge clk);
        chk("rmw rd stall", stall, 1);
        chk("rmw rd dm_we", dm_we, 0);
        chk("rmw rd dm_addr", dm_addr, a >> 2);
        tick();
        @(negedge clk);
        chk("rmw wr stall", stall, 0);
        chk("rmw wr dm_we", dm_we, 1);
        tick();
        idle();
    endtask

    task automatic store_word(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, SIZE_WORD, 1'b0, a, d);
        wr_q.push_back({a >> 2, d});
        @(negedge clk);
        chk("sw stall", stall, 0);
        chk("sw dm_we", dm_we, 1);
        tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        pre = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", stall, 0);
        chk("reset dm_we", dm_we, 0);
        chk("reset dm_wdata", dm_wdata, 0);
        chk("reset rdata", rdata, 0);
        chk("reset align_err", align_err, 0);
        drive(1'b1, 1'b1, SIZE_BYTE, 1'b0, 32'h12, 32'h55);
        #1;
        chk("reset gated stall", stall, 0);
        idle();
        tick();
        rst = 1'b0;
        preload();

        load(32'h11, SIZE_BYTE, 1'b0, 32'hFFFFFFAA);
        load(32'h11, SIZE_BYTE, 1'b1, 32'h000000AA);
        load(32'h12, SIZE_HALF, 1'b0, 32'hFFFF8899);
        load(32'h10, SIZE_HALF, 1'b1, 32'h0000AABB);
        load(32'h13, SIZE_BYTE, 1'b0, 32'hFFFFFF88);
        load(32'h13, SIZE_BYTE, 1'b1, 32'h00000088);
        load(32'h10, SIZE_WORD, 1'b0, 32'h8899AABB);

        drive(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'hFFFFFFF0, 32'h12345678);
        @(negedge clk);
        chk("noreq dm_addr", dm_addr, 32'h0001FFFC);
        chk("noreq dm_we", dm_we, 0);
        chk("noreq stall", stall, 0);
        chk("noreq rdata", rdata, 0);
        tick();
        idle();

        store_sub(32'h12, SIZE_BYTE, 32'h00000055, 32'h8855AABB);
        load(32'h10, SIZE_WORD, 1'b0, 32'h8855AABB);
        load(32'h10, 2'b11, 1'b0, 32'h8855AABB);

        preload();
        store_sub(32'h10, SIZE_HALF, 32'hFFFF1234, 32'h88991234);
        load(32'h10, SIZE_WORD, 1'b0, 32'h88991234);
        store_word(32'h10, 32'hDEADBEEF);
        load(32'h10, SIZE_WORD, 1'b0, 32'hDEADBEEF);

        preload();
        store_sub(32'h10, SIZE_BYTE, 32'h00000001, 32'h8899AA01);
        store_sub(32'h11, SIZE_BYTE, 32'h00000002, 32'h88990201);
        load(32'h10, SIZE_WORD, 1'b0, 32'h88990201);

        preload();
        drive(1'b1, 1'b1, SIZE_BYTE, 1'b0, 32'h12, 32'h55);
        @(negedge clk);
        chk("abort issue stall", stall, 1);
        tick();
        idle();
        rst = 1'b1;
        #1;
        chk("abort stall", stall, 0);
        chk("abort dm_we", dm_we, 0);
        tick();
        rst = 1'b0;
        tick();
        load(32'h10, SIZE_WORD, 1'b0, 32'h8899AABB);

`ifdef ALIGN_CHECK_EN
        drive(1'b1, 1'b0, SIZE_HALF, 1'b0, 32'h11, 32'h0);
        load_q.push_back(32'h0);
        @(negedge clk);
        chk("mis lh align_err", align_err, 1);
        tick();
        idle();
        drive(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h12, 32'hDEADBEEF);
        @(negedge clk);
        chk("mis sw align_err", align_err, 1);
        chk("mis sw dm_we", dm_we, 0);
        chk("mis sw stall", stall, 0);
        tick();
        idle();
        load(32'h10, SIZE_WORD, 1'b0, 32'h8899AABB);
`else
        drive(1'b1, 1'b0, SIZE_HALF, 1'b0, 32'h11, 32'h0);
        load_q.push_back(32'hFFFFAABB);
        @(negedge clk);
        chk("lh odd align_err", align_err, 0);
        tick();
        idle();
        drive(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h12, 32'hDEADBEEF);
        wr_q.push_back({32'h4, 32'hDEADBEEF});
        @(negedge clk);
        chk("sw odd align_err", align_err, 0);
        tick();
        idle();
        load(32'h10, SIZE_WORD, 1'b0, 32'hDEADBEEF);
`endif

        tick();
        chk("load queue drained", load_q.size(), 0);
        chk("write queue drained", wr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
